vc_tdm_arbiter: RTL and testbench

Time-division-multiplexed arbiter that shares one downstream port (memory or bus slave) among three requesters tagged with security domains. Unlike a demand-driven round-robin arbiter, the grant schedule is fixed. When a requester is served depends only on its own requests and the global slot count, never on other requesters' activity, so contention does not open a timing channel between domains. It sits between the three master-side request interfaces and the shared slave port, and replaces demand-driven arbitration wherever cross-domain contention must be non-interfering.

---
 rtl/vc_tdm_arbiter_if.sv | 28 ++
 rtl/vc_tdm_arbiter.sv | 82 ++++++++
 tb/tb_vc_tdm_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vc_tdm_arbiter_if.sv
// Request/grant bundle between three requesters, the TDM arbiter and the shared port.
// The arbiter takes the slave view; requesters and the downstream port take the master view.
interface vc_tdm_arbiter_if;
   logic       in0_domain;
   logic       in1_domain;
   logic       in2_domain;
   logic       req0;
   logic       req1;
   logic       req2;
   logic       gnt0;
   logic       gnt1;
   logic       gnt2;
   logic       out_val;
   logic       out_rdy;
   logic [1:0] out_sel;
   logic       out_domain;
   logic       slot_start;

   modport master (
      output in0_domain, in1_domain, in2_domain, req0, req1, req2, out_rdy,
      input  gnt0, gnt1, gnt2, out_val, out_sel, out_domain, slot_start
   );

   modport slave (
      input  in0_domain, in1_domain, in2_domain, req0, req1, req2, out_rdy,
      output gnt0, gnt1, gnt2, out_val, out_sel, out_domain, slot_start
   );
endinterface

// File: rtl/vc_tdm_arbiter.sv
// Fixed-schedule TDM arbiter: three requesters share one downstream port, each owning
// every third slot, so one domain's traffic never shifts another domain's grant timing.
module vc_tdm_arbiter #(
   parameter int unsigned SLOT_CYCLES = 4
) (
   input  logic            clk,
   input  logic            rst,
   vc_tdm_arbiter_if.slave bus
);
   localparam int unsigned CNT_W = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_CYCLES - 1);

   typedef enum logic {
      ST_OPEN = 1'b0,
      ST_USED = 1'b1
   } state_e;

   state_e           state_q;
   state_e           state_d;
   logic [1:0]       owner_q;
   logic [1:0]       owner_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             guard;
   logic             owner_req;
   logic             owner_dom;
   logic             out_val;
   logic             fire;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_OPEN;
         owner_q <= 2'd0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      cnt_d     = cnt_q + CNT_W'(1);
      owner_req = 1'b0;
      owner_dom = bus.in0_domain;

      // Only the slot owner's request is ever sampled; other requesters cannot reach its grant.
      case (owner_q)
         2'd0: begin owner_req = bus.req0; owner_dom = bus.in0_domain; end
         2'd1: begin owner_req = bus.req1; owner_dom = bus.in1_domain; end
         2'd2: begin owner_req = bus.req2; owner_dom = bus.in2_domain; end
         default: begin owner_req = 1'b0; owner_dom = bus.in0_domain; end
      endcase

      guard   = (cnt_q == CNT_LAST);
      out_val = !rst && (state_q == ST_OPEN) && !guard && owner_req;
      fire    = out_val && bus.out_rdy;

      if (guard) begin
         cnt_d   = '0;
         state_d = ST_OPEN;
         owner_d = (owner_q == 2'd2) ? 2'd0 : owner_q + 2'd1;
      end else if (fire) begin
         state_d = ST_USED;
      end

      // Unreachable owner value recovers on the very next edge.
      if (owner_q == 2'd3) begin
         owner_d = 2'd0;
      end
   end

   assign bus.out_val    = out_val;
   assign bus.gnt0       = fire && (owner_q == 2'd0);
   assign bus.gnt1       = fire && (owner_q == 2'd1);
   assign bus.gnt2       = fire && (owner_q == 2'd2);
   assign bus.out_sel    = owner_q;
   assign bus.out_domain = owner_dom;
   assign bus.slot_start = !rst && (cnt_q == '0);
endmodule

// File: tb/tb_vc_tdm_arbiter.sv
// Directed bench for vc_tdm_arbiter: fixed TDM schedule, backpressure, guard cycle,
// non-interference, async reset and the minimum slot length.
module tb_vc_tdm_arbiter;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   vc_tdm_arbiter_if bus_a ();
   vc_tdm_arbiter_if bus_b ();

   vc_tdm_arbiter #(.SLOT_CYCLES(4)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
   vc_tdm_arbiter #(.SLOT_CYCLES(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_inputs();
      bus_a.req0 = 1'b0; bus_a.req1 = 1'b0; bus_a.req2 = 1'b0; bus_a.out_rdy = 1'b0;
      bus_a.in0_domain = 1'b0; bus_a.in1_domain = 1'b0; bus_a.in2_domain = 1'b0;
      bus_b.req0 = 1'b0; bus_b.req1 = 1'b0; bus_b.req2 = 1'b0; bus_b.out_rdy = 1'b0;
      bus_b.in0_domain = 1'b0; bus_b.in1_domain = 1'b0; bus_b.in2_domain = 1'b0;
   endtask

   // Leaves the bench at the negedge that begins cycle 0.
   task automatic reset_seq();
      @(negedge clk);
      rst = 1'b1;
      clear_inputs();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      bus_a.req0 = 1'b1; bus_a.out_rdy = 1'b1; bus_a.in0_domain = 1'b1;
      #1;
      checks++;
      if (bus_a.out_val !== 1'b0) begin errors++; $display("FAIL reset_out_val got %b exp 0", bus_a.out_val); end
      checks++;
      if ({bus_a.gnt2, bus_a.gnt1, bus_a.gnt0} !== 3'b000) begin
         errors++; $display("FAIL reset_gnt got %b exp 000", {bus_a.gnt2, bus_a.gnt1, bus_a.gnt0});
      end
      checks++;
      if (bus_a.slot_start !== 1'b0) begin errors++; $display("FAIL reset_slot_start got %b exp 0", bus_a.slot_start); end
      checks++;
      if (bus_a.out_sel !== 2'd0) begin errors++; $display("FAIL reset_out_sel got %0d exp 0", bus_a.out_sel); end
      checks++;
      if (bus_a.out_domain !== 1'b1) begin errors++; $display("FAIL reset_out_domain got %b exp 1", bus_a.out_domain); end
      bus_a.in0_domain = 1'b0;
      #1;
      checks++;
      if (bus_a.out_domain !== 1'b0) begin errors++; $display("FAIL reset_out_domain_follow got %b exp 0", bus_a.out_domain); end
      rst = 1'b0;
      #1;
      checks++;
      if (bus_a.gnt0 !== 1'b1) begin errors++; $display("FAIL reset_release_gnt0 got %b exp 1", bus_a.gnt0); end
   endtask

   task automatic test_all_busy();
      logic [2:0] exp_g;
      logic [1:0] own;
      reset_seq();
      for (int c = 0; c < 24; c++) begin
         bus_a.req0 = 1'b1; bus_a.req1 = 1'b1; bus_a.req2 = 1'b1; bus_a.out_rdy = 1'b1;
         bus_a.in0_domain = 1'b0; bus_a.in1_domain = 1'b1; bus_a.in2_domain = 1'b0;
         #1;
         own   = 2'((c / 4) % 3);
         exp_g = (c % 4 == 0) ? (3'b001 << own) : 3'b000;
         checks++;
         if ({bus_a.gnt2, bus_a.gnt1, bus_a.gnt0} !== exp_g) begin
            errors++; $display("FAIL busy_gnt c=%0d got %b exp %b", c, {bus_a.gnt2, bus_a.gnt1, bus_a.gnt0}, exp_g);
         end
         checks++;
         if (bus_a.out_sel !== own) begin errors++; $display("FAIL busy_sel c=%0d got %0d exp %0d", c, bus_a.out_sel, own); end
         checks++;
         if (bus_a.out_domain !== (own == 2'd1)) begin
            errors++; $display("FAIL busy_domain c=%0d got %b exp %b", c, bus_a.out_domain, (own == 2'd1));
         end
         checks++;
         if (bus_a.slot_start !== (c % 4 == 0)) begin
            errors++; $display("FAIL busy_slot_start c=%0d got %b exp %b", c, bus_a.slot_start, (c % 4 == 0));
         end
         @(negedge clk);
      end
   endtask

   task automatic test_single_req();
      logic [2:0] exp_g;
      reset_seq();
      for (int c = 0; c < 20; c++) begin
         bus_a.req1 = (c <= 4) || (c >= 10);
         bus_a.out_rdy = 1'b1;
         #1;
         exp_g = (c == 4 || c == 16) ? 3'b010 : 3'b000;
         checks++;
         if ({bus_a.gnt2, bus_a.gnt1, bus_a.gnt0} !== exp_g) begin
            errors++; $display("FAIL single_gnt c=%0d got %b exp %b", c, {bus_a.gnt2, bus_a.gnt1, bus_a.gnt0}, exp_g);
         end
         checks++;
         if (bus_a.out_val !== exp_g[1]) begin
            errors++; $display("FAIL single_out_val c=%0d got %b exp %b", c, bus_a.out_val, exp_g[1]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_backpressure();
      logic exp_v;
      reset_seq();
      for (int c = 0; c < 20; c++) begin
         bus_a.req1 = (c <= 16);
         bus_a.out_rdy = (c < 4) || (c >= 7);
         #1;
         exp_v = ((c >= 4) && (c <= 6)) || (c == 16);
         checks++;
         if (bus_a.gnt1 !== (c == 16)) begin errors++; $display("FAIL bp_gnt1 c=%0d got %b exp %b", c, bus_a.gnt1, (c == 16)); end
         checks++;
         if (bus_a.out_val !== exp_v) begin errors++; $display("FAIL bp_out_val c=%0d got %b exp %b", c, bus_a.out_val, exp_v); end
         @(negedge clk);
      end
      reset_seq();
      for (int c = 0; c < 16; c++) begin
         bus_a.req1 = 1'b0;
         bus_a.req0 = (c >= 3) && (c <= 12);
         bus_a.out_rdy = 1'b1;
         #1;
         checks++;
         if (bus_a.gnt0 !== (c == 12)) begin errors++; $display("FAIL late_req_gnt0 c=%0d got %b exp %b", c, bus_a.gnt0, (c == 12)); end
         @(negedge clk);
      end
   endtask

   task automatic test_non_interference();
      logic r1 [36];
      logic rd [36];
      logic g_run1 [36];
      logic exp_g;
      logic used;
      for (int i = 0; i < 36; i++) begin
         r1[i] = 1'($urandom_range(0, 1));
         rd[i] = 1'($urandom_range(0, 3) != 0);
      end
      for (int run = 0; run < 2; run++) begin
         reset_seq();
         used = 1'b0;
         for (int c = 0; c < 36; c++) begin
            bus_a.req1 = r1[c];
            bus_a.out_rdy = rd[c];
            bus_a.req0 = (run == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus_a.req2 = (run == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            if (c % 4 == 0) used = 1'b0;
            exp_g = ((c / 4) % 3 == 1) && (c % 4 != 3) && !used && r1[c] && rd[c];
            if (exp_g) used = 1'b1;
            checks++;
            if (bus_a.gnt1 !== exp_g) begin
               errors++; $display("FAIL ni_gnt1 run=%0d c=%0d got %b exp %b", run, c, bus_a.gnt1, exp_g);
            end
            if (run == 0) begin
               g_run1[c] = bus_a.gnt1;
            end else begin
               checks++;
               if (bus_a.gnt1 !== g_run1[c]) begin
                  errors++; $display("FAIL ni_replay c=%0d got %b exp %b", c, bus_a.gnt1, g_run1[c]);
               end
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_async_reset();
      reset_seq();
      for (int c = 0; c < 5; c++) begin
         bus_a.req1 = 1'b1;
         bus_a.out_rdy = (c != 4);
         #1;
         checks++;
         if (bus_a.gnt1 !== 1'b0) begin errors++; $display("FAIL ar_pre_gnt1 c=%0d got %b exp 0", c, bus_a.gnt1); end
         @(negedge clk);
      end
      bus_a.out_rdy = 1'b1;
      #1;
      checks++;
      if (bus_a.gnt1 !== 1'b1) begin errors++; $display("FAIL ar_c5_gnt1 got %b exp 1", bus_a.gnt1); end
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if (bus_a.gnt1 !== 1'b0) begin errors++; $display("FAIL ar_drop_gnt1 got %b exp 0", bus_a.gnt1); end
      checks++;
      if (bus_a.out_val !== 1'b0) begin errors++; $display("FAIL ar_drop_out_val got %b exp 0", bus_a.out_val); end
      checks++;
      if (bus_a.out_sel !== 2'd0) begin errors++; $display("FAIL ar_out_sel got %0d exp 0", bus_a.out_sel); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         #1;
         if (c == 0) begin
            checks++;
            if (bus_a.slot_start !== 1'b1) begin errors++; $display("FAIL ar_new_slot_start got %b exp 1", bus_a.slot_start); end
         end
         checks++;
         if (bus_a.gnt1 !== (c == 4)) begin errors++; $display("FAIL ar_post_gnt1 c=%0d got %b exp %b", c, bus_a.gnt1, (c == 4)); end
         @(negedge clk);
      end
      bus_a.req1 = 1'b0;
   endtask

   task automatic test_min_slot();
      logic [2:0] exp_g;
      logic [1:0] own;
      reset_seq();
      for (int c = 0; c < 8; c++) begin
         bus_b.req0 = 1'b1; bus_b.req1 = 1'b1; bus_b.req2 = 1'b1; bus_b.out_rdy = 1'b1;
         #1;
         own   = 2'((c / 2) % 3);
         exp_g = (c % 2 == 0) ? (3'b001 << own) : 3'b000;
         checks++;
         if ({bus_b.gnt2, bus_b.gnt1, bus_b.gnt0} !== exp_g) begin
            errors++; $display("FAIL min_gnt c=%0d got %b exp %b", c, {bus_b.gnt2, bus_b.gnt1, bus_b.gnt0}, exp_g);
         end
         checks++;
         if (bus_b.out_sel !== own) begin errors++; $display("FAIL min_sel c=%0d got %0d exp %0d", c, bus_b.out_sel, own); end
         @(negedge clk);
      end
   endtask

   task automatic test_illegal_owner();
      reset_seq();
      bus_b.req0 = 1'b1; bus_b.req1 = 1'b1; bus_b.req2 = 1'b1; bus_b.out_rdy = 1'b1;
      repeat (5) @(negedge clk);
      // Cycle 5: guard cycle of an owner-2 slot.
      force dut_b.owner_q = 2'd3;
      #1;
      checks++;
      if (bus_b.out_sel !== 2'd3) begin errors++; $display("FAIL illegal_sel got %0d exp 3", bus_b.out_sel); end
      checks++;
      if ({bus_b.out_val, bus_b.gnt2, bus_b.gnt1, bus_b.gnt0} !== 4'b0000) begin
         errors++; $display("FAIL illegal_quiet got %b exp 0000", {bus_b.out_val, bus_b.gnt2, bus_b.gnt1, bus_b.gnt0});
      end
      release dut_b.owner_q;
      @(negedge clk);
      #1;
      checks++;
      if (bus_b.out_sel !== 2'd0) begin errors++; $display("FAIL illegal_recover_sel got %0d exp 0", bus_b.out_sel); end
      checks++;
      if (bus_b.gnt0 !== 1'b1) begin errors++; $display("FAIL illegal_recover_gnt0 got %b exp 1", bus_b.gnt0); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      clear_inputs();
      test_reset();
      test_all_busy();
      test_single_req();
      test_backpressure();
      test_non_interference();
      test_async_reset();
      test_min_slot();
      test_illegal_owner();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
